// File: rtl/regfile_rv32i_pkg.sv
// Shared RV32I register-file constants: widths, register count and the
// two-state control encoding used by the clear sequencer.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_FIRST = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_LAST  = 5'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_rv32i_if.sv
// Register-file bus: two read ports, one write port and the init_done
// status. The core drives through master, the register file through slave.
interface regfile_rv32i_if;
    import rv32i_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
    logic                  init_done;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data,
        input  rs1_data, rs2_data, init_done
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
        output rs1_data, rs2_data, init_done
    );

endinterface

// File: rtl/regfile_rv32i.sv
// RV32I integer register file x0..x31: two combinational read ports, one
// synchronous write port. After every reset a sequencer zeroes x1..x31, one
// register per cycle, and then raises init_done. x0 is not stored.
module regfile_rv32i #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_rv32i_if.slave  bus
);
    import rv32i_pkg::*;

    state_t                state, state_nx;
    logic [REG_ADDR_W-1:0] clr_cnt, clr_cnt_nx;

    // Array is deliberately not reset; the INIT sequence owns clearing it.
    logic [XLEN-1:0]       regs [1:NUM_REGS-1];

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    // Read mux: x0 and the whole INIT window read as zero so nothing
    // uninitialised leaks out; optional write-first forwarding in RUN.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       stored
    );
        if (addr == REG_ZERO || state == ST_INIT)
            return '0;
        if (BYPASS && bus.we && bus.rd_addr == addr)
            return bus.rd_data;
        return stored;
    endfunction

    // Control state: reset restarts the clear sequence from x1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_cnt <= REG_FIRST;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // Next state and write-port steering: sequencer owns the port in INIT,
    // the core owns it in RUN (writes to x0 dropped).
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        wr_en      = 1'b0;
        wr_addr    = bus.rd_addr;
        wr_data    = bus.rd_data;
        case (state)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
                wr_data = '0;
                if (clr_cnt == REG_LAST)
                    state_nx = ST_RUN;
                else
                    clr_cnt_nx = clr_cnt + 5'd1;
            end
            ST_RUN: begin
                wr_en = bus.we && (bus.rd_addr != REG_ZERO);
            end
            default: ;
        endcase
    end

    // Array write; a reset edge never commits data.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            regs[wr_addr] <= wr_data;
    end

    assign bus.rs1_data  = read_mux(bus.rs1_addr, regs[bus.rs1_addr]);
    assign bus.rs2_data  = read_mux(bus.rs2_addr, regs[bus.rs2_addr]);
    assign bus.init_done = (state == ST_RUN);

endmodule
